stage_waveform_generator: RTL
=============================

Name: stage_waveform_generator

Overview:
- Pipeline stage directly downstream of the phase accumulator.
- Takes each operator's accumulated unsigned phase, adds a signed modulation phase and a per-operator self-feedback term, and converts the result to a signed sine sample using a quarter-wave ROM.
- Keeps per-operator feedback history and feedback-level configuration in RAM. After reset, a clear sweep initialises both RAMs before the stage accepts samples.

Parameters:
- NUM_VOICE_OPERATORS, `NUM_VOICE_OPERATORS (synth.svh): number of time-multiplexed voice operators; sets RAM depth and clear-sweep length.
- SINE_QUARTER_BITS, 8: quarter-wave ROM address width (256 entries).
- FEEDBACK_BITS, 3: width of the per-operator feedback level.

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  synchronous, active-low reset
- i_Valid  in  1  i_Phase, i_ModulationPhase and i_VoiceOperator are valid this cycle
- i_Phase  in  16  unsigned accumulated phase
- i_ModulationPhase  in  16  signed modulation phase, same cycle as i_Phase
- i_VoiceOperator  in  VoiceOperatorID_t  operator tag for i_Phase
- i_FeedbackConfigWriteEnable  in  1  feedback-level config write strobe
- i_FeedbackConfigWriteAddr  in  VoiceOperatorID_t  config write address
- i_FeedbackConfigWriteData  in  FEEDBACK_BITS  feedback level, 0 = off
- o_Ready  out  1  clear sweep done; inputs accepted
- o_Valid  out  1  o_Waveform valid
- o_Waveform  out  16  signed sine sample
- o_VoiceOperator  out  VoiceOperatorID_t  tag for o_Waveform

Behaviour:
- Clocking and reset: one clock, i_Clock. Reset is synchronous and active-low.
  - While i_Reset_n=0 at a posedge: o_Ready=0, o_Valid=0, o_Waveform=0, o_VoiceOperator=0, all pipeline valids=0, FSM=CLEAR, sweep counter=0.
- FSM CLEAR:
  - Each cycle writes 0 to FeedbackHistory[cnt] and FeedbackLevel[cnt], then cnt++.
  - After the write to cnt=NUM_VOICE_OPERATORS-1, go to RUN.
  - o_Ready rises exactly NUM_VOICE_OPERATORS cycles after the first posedge with i_Reset_n=1.
  - In CLEAR, i_Valid is ignored (treated as 0) and config writes are dropped.
- FSM RUN:
  - Stays in RUN until reset. Config writes take effect on the next clock edge.
  - i_Valid is accepted every cycle; there is no backpressure.
- Latency: 3 clocks from i_Valid to o_Valid. o_VoiceOperator travels with its sample.
- C1 (register stage):
  - Register phase, modulation, valid and operator.
  - Read FeedbackHistory[op] (16-bit signed) and FeedbackLevel[op].
- C2 (phase combine and ROM read):
  - fb = 0 if level==0, else history >>> (8-level) (arithmetic shift).
  - total = phase + mod + fb, computed mod 2^16 (wrap-around, no saturation).
  - quadrant = total[15:14]; idx = total[13:6]. If quadrant[0]=1, idx = ~idx.
  - ROM read is registered.
- Sine ROM: ROM[i] = round(32767*sin(2*pi*(i+0.5)/1024)), i = 0..255. All entries positive, maximum 32767.
- C3 (output):
  - o_Waveform = quadrant[1] ? -ROM : ROM. Negation never overflows.
  - When valid, also write FeedbackHistory[op] <= o_Waveform value.
- Read-after-write ordering:
  - The same operator must not reappear within 3 cycles. If it does, the stale history is used; this is defined, not an error.
  - A history write and read of the same address in one cycle returns the old data.
- Reset mid-operation: in-flight samples are discarded (o_Valid=0 next cycle) and a full clear sweep re-runs.
- Simultaneous config write and pipeline read of the same address: the read returns the old level.

Decomposition:
- Shared synth package:
  - VoiceOperatorID_t
  - FeedbackLevel_t (FEEDBACK_BITS)
  - WaveformSample_t (signed 16)
  - ROM-size constants
- Sub-module sine_quarter_rom:
  - Registered 256x15 ROM, contents generated as defined above.
  - Latency 1.
- The clear-sweep FSM stays inline.

Test Plan:
- Reset release -> o_Ready=0 for exactly NUM_VOICE_OPERATORS cycles then 1; o_Valid=0 throughout; i_Valid pulses during CLEAR produce no output.
- Phases 0x0000/0x4000/0x8000/0xC000, mod=0, level=0 -> o_Waveform = +101/+32767/-101/-32767, each 3 cycles after its input with matching o_VoiceOperator.
- Phase 0xF000 + mod 0x2000 -> output identical to phase 0x1000, mod 0 (wrap-around).
- Feedback: level 7 on op 5, op 5 previous output 32767, next op 5 sample phase 0x0000 -> total phase 0x3FFF (16383) -> output ROM[255] = 32767; same with level 0 -> 101.
- Assert reset with 3 samples in flight -> no o_Valid after reset; after a new sweep, op 5 feedback history reads 0.
- Config write during CLEAR (op 2, level 7) is dropped (op 2 feedback stays 0); the same write in RUN takes effect for the next op 2 sample.

Source files
------------

// File: rtl/stage_waveform_generator_pkg.sv
// Shared types and constants for the waveform stage: operator tags, feedback levels,
// sample format and the quarter-wave sine table generator used at elaboration.
package stage_waveform_generator_pkg;

    localparam int NUM_VOICE_OPERATORS = 8;
    localparam int VOICE_OPERATOR_BITS = $clog2(NUM_VOICE_OPERATORS);
    localparam int FEEDBACK_BITS       = 3;
    localparam int SINE_QUARTER_BITS   = 8;
    localparam int SINE_QUARTER_DEPTH  = 1 << SINE_QUARTER_BITS;
    localparam int SINE_SAMPLE_BITS    = 15;
    localparam int WAVEFORM_BITS       = 16;

    // pi scaled by 2^60
    localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

    typedef logic [VOICE_OPERATOR_BITS-1:0]  VoiceOperatorID_t;
    typedef logic [FEEDBACK_BITS-1:0]        FeedbackLevel_t;
    typedef logic signed [WAVEFORM_BITS-1:0] WaveformSample_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sweep_state_t;

    // round(32767 * sin(pi * (2*idx + 1) / 1024)) via a Q60 Taylor series; constant-evaluated only
    function automatic logic [SINE_SAMPLE_BITS-1:0] sine_entry(input int idx);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] acc;
        x    = (128'(PI_Q60) * 128'(2 * idx + 1)) >> 10;
        x2   = (x * x) >> 60;
        term = x;
        acc  = x;
        for (int k = 1; k <= 12; k++) begin
            term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
            if (k[0]) acc = acc - term;
            else      acc = acc + term;
        end
        return SINE_SAMPLE_BITS'((acc * 128'd32767 + (128'd1 << 59)) >> 60);
    endfunction

endpackage

// File: rtl/stage_waveform_generator_sine_quarter_rom.sv
// Registered 256x15 quarter-wave sine ROM; one clock from address to data.
module sine_quarter_rom
    import stage_waveform_generator_pkg::*;
(
    input  logic                         i_Clock,
    input  logic [SINE_QUARTER_BITS-1:0] i_Addr,
    output logic [SINE_SAMPLE_BITS-1:0]  o_Data
);

    logic [SINE_SAMPLE_BITS-1:0] w_table [SINE_QUARTER_DEPTH];
    logic [SINE_SAMPLE_BITS-1:0] r_data;

    for (genvar g = 0; g < SINE_QUARTER_DEPTH; g++) begin : g_entry
        localparam logic [SINE_SAMPLE_BITS-1:0] ENTRY = sine_entry(g);
        assign w_table[g] = ENTRY;
    end

    always_ff @(posedge i_Clock) begin
        r_data <= w_table[i_Addr];
    end

    assign o_Data = r_data;

endmodule

// File: rtl/stage_waveform_generator.sv
// Phase-to-sine stage: phase + modulation + per-operator self-feedback, quarter-wave lookup.
// state    | meaning
// ST_CLEAR | zeroing feedback history and level RAMs, inputs ignored
// ST_RUN   | accepting one sample per cycle, config writes enabled
module stage_waveform_generator
    import stage_waveform_generator_pkg::*;
(
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Valid,
    input  logic [15:0]      i_Phase,
    input  logic [15:0]      i_ModulationPhase,
    input  VoiceOperatorID_t i_VoiceOperator,
    input  logic             i_FeedbackConfigWriteEnable,
    input  VoiceOperatorID_t i_FeedbackConfigWriteAddr,
    input  FeedbackLevel_t   i_FeedbackConfigWriteData,
    output logic             o_Ready,
    output logic             o_Valid,
    output logic [15:0]      o_Waveform,
    output VoiceOperatorID_t o_VoiceOperator
);

    sweep_state_t     r_state;
    sweep_state_t     w_state_next;
    VoiceOperatorID_t r_clear_cnt;
    logic             w_clear_active;
    logic             w_ready;

    WaveformSample_t  r_history_mem [NUM_VOICE_OPERATORS];
    FeedbackLevel_t   r_level_mem   [NUM_VOICE_OPERATORS];

    logic             r1_valid;
    logic [15:0]      r1_phase;
    WaveformSample_t  r1_mod;
    VoiceOperatorID_t r1_op;
    WaveformSample_t  r1_history;
    FeedbackLevel_t   r1_level;

    logic [2:0]       w_fb_shift;
    WaveformSample_t  w_feedback;
    logic [15:0]      w_total;
    logic [SINE_QUARTER_BITS-1:0] w_rom_addr;
    logic             w_unused_lsbs;

    logic             r2_valid;
    VoiceOperatorID_t r2_op;
    logic             r2_negate;
    logic [SINE_SAMPLE_BITS-1:0] w_rom_data;
    WaveformSample_t  w_magnitude;
    WaveformSample_t  w_waveform;

    logic             r_out_valid;
    WaveformSample_t  r_out_waveform;
    VoiceOperatorID_t r_out_op;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) r_state <= ST_CLEAR;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_clear_active = 1'b0;
        w_ready        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clear_active = 1'b1;
                if (r_clear_cnt == VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1)) w_state_next = ST_RUN;
            end
            ST_RUN:  w_ready = 1'b1;
            default: w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n)          r_clear_cnt <= '0;
        else if (w_clear_active) r_clear_cnt <= r_clear_cnt + 1'b1;
    end

    // Single write port per RAM: the sweep owns both RAMs until RUN
    always_ff @(posedge i_Clock) begin
        if (i_Reset_n) begin
            if (w_clear_active) begin
                r_history_mem[r_clear_cnt] <= '0;
                r_level_mem[r_clear_cnt]   <= '0;
            end else begin
                if (i_FeedbackConfigWriteEnable)
                    r_level_mem[i_FeedbackConfigWriteAddr] <= i_FeedbackConfigWriteData;
                if (r2_valid)
                    r_history_mem[r2_op] <= w_waveform;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        r1_phase   <= i_Phase;
        r1_mod     <= i_ModulationPhase;
        r1_op      <= i_VoiceOperator;
        r1_history <= r_history_mem[i_VoiceOperator];
        r1_level   <= r_level_mem[i_VoiceOperator];
        r2_op      <= r1_op;
        r2_negate  <= w_total[15];
    end

    always_comb begin
        w_fb_shift = 3'(4'd8 - {1'b0, r1_level});
        w_feedback = '0;
        if (r1_level != '0) w_feedback = r1_history >>> w_fb_shift;
        w_total    = r1_phase + r1_mod + w_feedback;
        w_rom_addr = w_total[14] ? ~w_total[13:6] : w_total[13:6];
    end

    assign w_unused_lsbs = ^w_total[5:0];

    sine_quarter_rom u_sine_quarter_rom (
        .i_Clock (i_Clock),
        .i_Addr  (w_rom_addr),
        .o_Data  (w_rom_data)
    );

    // ROM entries top out at 32767, so negation stays in range
    always_comb begin
        w_magnitude = WaveformSample_t'({1'b0, w_rom_data});
        w_waveform  = r2_negate ? -w_magnitude : w_magnitude;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r1_valid       <= 1'b0;
            r2_valid       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_waveform <= '0;
            r_out_op       <= '0;
        end else begin
            r1_valid    <= i_Valid && w_ready;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_out_waveform <= w_waveform;
                r_out_op       <= r2_op;
            end
        end
    end

    assign o_Ready         = w_ready;
    assign o_Valid         = r_out_valid;
    assign o_Waveform      = r_out_waveform;
    assign o_VoiceOperator = r_out_op;

endmodule
